// File: rtl/serial_subtractor16.sv
// Digit-serial subtractor: a - b - bin computed DIGIT bits per cycle as a + ~b + ~bin,
// with borrow-out taken as the inverted final carry.
module serial_subtractor16 #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start, last result held on diff/bout/ovf
  // RUN   | one digit processed per cycle, NDIG cycles
  // DONE  | one-cycle done pulse; start here begins the next operation
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, acc, acc_nxt, s_ext;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] s_dig;
  logic             carry, cout, a_msb, b_msb, accept, last;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == CW'(NDIG - 1));

  assign {cout, s_dig} = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, ~b_sr[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, carry};
  assign s_ext   = WIDTH'(s_dig);
  // New digit enters at the MSB end so the LSB digit lands at bit 0 after NDIG shifts
  assign acc_nxt = (acc >> DIGIT) | (s_ext << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      acc   <= '0;
      cnt   <= '0;
      carry <= ~bin;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN) begin
      a_sr  <= a_sr >> DIGIT;
      b_sr  <= b_sr >> DIGIT;
      acc   <= acc_nxt;
      carry <= cout;
      cnt   <= cnt + CW'(1);
      if (last) begin
        diff <= acc_nxt;
        bout <= ~cout;
        ovf  <= (a_msb != b_msb) && (acc_nxt[WIDTH-1] != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor16.sv
// Bench for serial_subtractor16: directed vectors, handshake/reset sequences and
// random operands against an arithmetic model, on DIGIT = 4 plus DIGIT = 1, 2, 8, 16.
module tb_serial_subtractor16;

  logic        clk, rst_n, start, bin;
  logic [15:0] a, b;
  logic        busy, done, bout, ovf;
  logic [15:0] diff;

  logic [3:0]  busyx, donex, boutx, ovfx;
  logic [15:0] diffx [4];

  int total = 0;
  int bad   = 0;
  int cyc;
  logic [15:0] prev_diff;

  serial_subtractor16 #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  for (genvar g = 0; g < 4; g++) begin : gx
    localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    serial_subtractor16 #(.WIDTH(16), .DIGIT(D)) u (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busyx[g]), .done(donex[g]), .diff(diffx[g]), .bout(boutx[g]), .ovf(ovfx[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic bi,
                                output logic [15:0] d, output logic bo, output logic ov);
    logic signed [15:0] xs, ys;
    int ua, ub, sa, sb, r, sr;
    xs = x;
    ys = y;
    ua = int'(x);
    ub = int'(y);
    sa = xs;
    sb = ys;
    r  = ua - ub - int'(bi);
    sr = sa - sb - int'(bi);
    d  = r[15:0];
    bo = (ua < ub + int'(bi));
    ov = (sr > 32767) || (sr < -32768);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_diff = 16'h0;
  endtask

  // One operation on all five instances; latency counted in cycles after the start edge.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                        input logic [15:0] ed, input logic eb, input logic eo, input string nm);
    int dcyc, bcnt, dcnt;
    int xd [4];
    int nd;
    dcyc = 0; bcnt = 0; dcnt = 0;
    for (int g = 0; g < 4; g++) xd[g] = 0;
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    for (int c = 1; c <= 20; c++) begin
      if (c == 1) chk({nm, " hold"}, diff, prev_diff);
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (dcyc == 0) dcyc = c;
      end
      for (int g = 0; g < 4; g++) if (donex[g] && xd[g] == 0) xd[g] = c;
      @(negedge clk);
    end
    chk({nm, " done_cycle"}, dcyc, 5);
    chk({nm, " busy_cycles"}, bcnt, 4);
    chk({nm, " done_pulses"}, dcnt, 1);
    chk({nm, " diff"}, diff, ed);
    chk({nm, " bout"}, bout, eb);
    chk({nm, " ovf"}, ovf, eo);
    for (int g = 0; g < 4; g++) begin
      nd = (g == 0) ? 16 : (g == 1) ? 8 : (g == 2) ? 2 : 1;
      chk($sformatf("%s d%0d latency", nm, 16 / nd), xd[g], nd + 1);
      chk($sformatf("%s d%0d diff", nm, 16 / nd), diffx[g], ed);
      chk($sformatf("%s d%0d bout", nm, 16 / nd), boutx[g], eb);
      chk($sformatf("%s d%0d ovf", nm, 16 / nd), ovfx[g], eo);
    end
    prev_diff = ed;
  endtask

  initial begin
    logic [15:0] ra, rb, md;
    logic        rbin, mb, mo;
    int          dc;

    vecs[0] = '{16'h0200, 16'h0001, 1'b0, 16'h01FF, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[4] = '{16'h0001, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{16'h5627, 16'h1234, 1'b0, 16'h43F3, 1'b0, 1'b0};
    vecs[7] = '{16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0};

    a = '0; b = '0; bin = 1'b0; start = 1'b0; rst_n = 1'b0;
    do_reset();
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst diff", diff, 0);
    chk("rst bout", bout, 0);
    chk("rst ovf", ovf, 0);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].ov,
             $sformatf("vec%0d", i));

    // start two cycles into RUN must be ignored
    @(negedge clk);
    cyc = 0;
    a = 16'h1000; b = 16'h0001; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 16'hFFFF; b = 16'h0000; bin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    while (!done && cyc < 30) step();
    chk("ignore done_cycle", cyc, 5);
    chk("ignore diff", diff, 16'h0FFF);
    chk("ignore bout", bout, 0);
    chk("ignore ovf", ovf, 0);
    step();
    chk("ignore no_restart busy", busy, 0);

    // start during the done cycle: back-to-back
    step();
    cyc = 0;
    a = 16'h0300; b = 16'h0100; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    while (!done && cyc < 30) step();
    chk("b2b first done_cycle", cyc, 5);
    chk("b2b first diff", diff, 16'h0200);
    a = 16'h5627; b = 16'h1234; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b busy", busy, 1);
    chk("b2b done_low", done, 0);
    chk("b2b hold", diff, 16'h0200);
    while (!done && cyc < 40) step();
    chk("b2b second done_cycle", cyc, 10);
    chk("b2b second diff", diff, 16'h43F3);
    chk("b2b second bout", bout, 0);

    // reset in the third RUN cycle
    step();
    cyc = 0;
    a = 16'h1234; b = 16'h0001; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst diff", diff, 0);
    chk("midrst bout", bout, 0);
    chk("midrst ovf", ovf, 0);
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) dc++;
      step();
    end
    chk("midrst no_done", dc, 0);
    prev_diff = 16'h0;
    run_op(16'h1234, 16'h0234, 1'b1, 16'h0FFF, 1'b0, 1'b0, "after_rst");

    do_reset();
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbin = 1'($urandom);
      if (i % 10 == 0) ra = rb;
      model(ra, rb, rbin, md, mb, mo);
      run_op(ra, rb, rbin, md, mb, mo, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
